// File: rtl/parity_stream_gen.sv
// Serial parity generator/checker for ASCII '0'/'1' groups separated by spaces.
// Each delimiter closes a group, and its result is registered for one cycle.
module parity_stream_gen #(
    parameter int GROUP_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_char,
    input  logic             mode_even,
    input  logic             check_en,
    output logic             out_valid,
    output logic             out_bit,
    output logic             err,
    output logic             len_err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_dbg
);
    // Handshake: in_char is consumed on every posedge where in_valid is high (no
    // backpressure). out_valid is a one-cycle pulse qualifying out_bit/err/len_err.
    localparam int CW = $clog2(GROUP_LEN + 2);
    localparam logic [CW-1:0] LEN_C  = CW'(GROUP_LEN);
    localparam logic [CW-1:0] LEN1_C = CW'(GROUP_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FULL    = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            par_q, par_d;
    logic            rx_q, rx_d;
    logic            even_q, even_d;
    logic            chk_q, chk_d;
    logic            out_valid_q, out_valid_d;
    logic            out_bit_q, out_bit_d;
    logic            err_q, err_d;
    logic            len_err_q, len_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic            is_bit;
    logic            is_delim;
    logic            bit_val;
    logic            group_even;
    logic [CW-1:0]   exp_cnt;
    logic [CW-1:0]   first_exp;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        par_d       = par_q;
        rx_d        = rx_q;
        even_d      = even_q;
        chk_d       = chk_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        err_d       = 1'b0;
        len_err_d   = 1'b0;
        err_count_d = err_count_q;

        is_bit     = in_valid && ((in_char == 8'h30) || (in_char == 8'h31));
        is_delim   = in_valid && (in_char == 8'h20);
        bit_val    = in_char[0];
        exp_cnt    = chk_q ? LEN1_C : LEN_C;
        first_exp  = check_en ? LEN1_C : LEN_C;
        // An empty group has nothing latched, so it takes the live mode.
        group_even = (state_q == S_IDLE) ? mode_even : even_q;

        if (is_bit) begin
            unique case (state_q)
                S_IDLE: begin
                    count_d = CW'(1);
                    par_d   = bit_val;
                    rx_d    = 1'b0;
                    even_d  = mode_even;
                    chk_d   = check_en;
                    state_d = (first_exp == CW'(1)) ? S_FULL : S_COLLECT;
                end
                S_COLLECT: begin
                    count_d = count_q + CW'(1);
                    if (count_q < LEN_C) par_d = par_q ^ bit_val;
                    else                 rx_d  = bit_val;
                    if (count_d == exp_cnt) state_d = S_FULL;
                end
                S_FULL:  state_d = S_OVER;
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end else if (is_delim) begin
            out_valid_d = 1'b1;
            out_bit_d   = group_even ? par_q : ~par_q;
            err_d       = chk_q && (state_q == S_FULL) && (rx_q != out_bit_d);
            len_err_d   = (state_q != S_FULL);
            if ((err_d || len_err_d) && (err_count_q != {CNT_W{1'b1}}))
                err_count_d = err_count_q + CNT_W'(1);
            state_d = S_IDLE;
            count_d = '0;
            par_d   = 1'b0;
            rx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            par_q       <= 1'b0;
            rx_q        <= 1'b0;
            even_q      <= 1'b0;
            chk_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            err_q       <= 1'b0;
            len_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            par_q       <= par_d;
            rx_q        <= rx_d;
            even_q      <= even_d;
            chk_q       <= chk_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            err_q       <= err_d;
            len_err_q   <= len_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign err       = err_q;
    assign len_err   = len_err_q;
    assign err_count = err_count_q;
    assign state_dbg = state_q;

endmodule
